// File: rtl/decode_stage.sv
// Purpose : decodes 32-bit instruction words into register/memory fields and enables.
// Latency : 1 cycle from input transfer to out_valid when the output stage is empty.
// Backpressure: output register + one-entry skid; in_ready = !skid_full, no path from out_ready.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   flush                    drops everything held (and any input offered that cycle)
//   in_valid/in_ready/code   instruction input handshake and word
//   out_valid/out_ready      decoded-output handshake
//   opcode, rdst2, rdst1, rsrc2, rsrc1, rsrc_add, rdst_add, immediate   decoded fields
//   we2, we1, re2, re1, mem_rd, mem_wr, illegal                          decoded enables
//   dec_count, ill_count     saturating counts of accepted / illegal instructions
module decode_stage #(
   parameter int REG_W    = 5,
   parameter int ADDR_W   = 8,
   parameter int ALU_LAST = 16,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       code,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [5:0]        opcode,
   output logic [REG_W-1:0]  rdst2,
   output logic [REG_W-1:0]  rdst1,
   output logic [REG_W-1:0]  rsrc2,
   output logic [REG_W-1:0]  rsrc1,
   output logic [ADDR_W-1:0] rsrc_add,
   output logic [ADDR_W-1:0] rdst_add,
   output logic [15:0]       immediate,
   output logic              we2,
   output logic              we1,
   output logic              re2,
   output logic              re1,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic              illegal,
   output logic [CNT_W-1:0]  dec_count,
   output logic [CNT_W-1:0]  ill_count
);

   localparam logic [5:0] OP_LDI   = 6'd0;
   localparam logic [5:0] OP_MOV   = 6'd1;
   localparam logic [5:0] OP_LD    = 6'd2;
   localparam logic [5:0] OP_ST    = 6'd3;
   localparam logic [5:0] OP_ALU0  = 6'd4;
   localparam logic [5:0] OP_ALUN  = 6'(ALU_LAST);

   typedef struct packed {
      logic [5:0]        opcode;
      logic [REG_W-1:0]  rdst2;
      logic [REG_W-1:0]  rdst1;
      logic [REG_W-1:0]  rsrc2;
      logic [REG_W-1:0]  rsrc1;
      logic [ADDR_W-1:0] rsrc_add;
      logic [ADDR_W-1:0] rdst_add;
      logic [15:0]       immediate;
      logic              we2;
      logic              we1;
      logic              re2;
      logic              re1;
      logic              mem_rd;
      logic              mem_wr;
      logic              illegal;
   } dec_t;

   dec_t dec_next;
   dec_t out_q;
   dec_t skid_q;
   logic out_valid_q;
   logic skid_full;
   logic in_xfer;

   assign in_ready = ~skid_full;
   assign in_xfer  = in_valid & in_ready;

   // Every field starts at zero so nothing leaks between formats.
   always_comb begin
      dec_next        = '0;
      dec_next.opcode = code[31:26];
      case (code[31:26])
         OP_LDI: begin
            dec_next.rdst2     = code[21 +: REG_W];
            dec_next.immediate = code[15:0];
            dec_next.we2       = 1'b1;
         end
         OP_MOV: begin
            dec_next.rdst2 = code[21 +: REG_W];
            dec_next.rsrc2 = code[0 +: REG_W];
            dec_next.we2   = 1'b1;
            dec_next.re2   = 1'b1;
         end
         OP_LD: begin
            dec_next.rdst2    = code[21 +: REG_W];
            dec_next.rsrc_add = code[0 +: ADDR_W];
            dec_next.we2      = 1'b1;
            dec_next.mem_rd   = 1'b1;
         end
         OP_ST: begin
            dec_next.rdst_add = code[18 +: ADDR_W];
            dec_next.rsrc2    = code[0 +: REG_W];
            dec_next.re2      = 1'b1;
            dec_next.mem_wr   = 1'b1;
         end
         default: begin
            if (code[31:26] >= OP_ALU0 && code[31:26] <= OP_ALUN) begin
               dec_next.rdst2 = code[21 +: REG_W];
               dec_next.rdst1 = code[16 +: REG_W];
               dec_next.rsrc2 = code[5 +: REG_W];
               dec_next.rsrc1 = code[0 +: REG_W];
               dec_next.we2   = 1'b1;
               dec_next.we1   = 1'b1;
               dec_next.re2   = 1'b1;
               dec_next.re1   = 1'b1;
            end else begin
               dec_next.illegal = 1'b1;
            end
         end
      endcase
   end

   // skid_full implies out_valid_q, and in_ready is low while the skid is
   // full, so a skid-to-output move never coincides with an input transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         skid_full   <= 1'b0;
         out_q       <= '0;
         skid_q      <= '0;
         dec_count   <= '0;
         ill_count   <= '0;
      end else if (flush) begin
         out_valid_q <= 1'b0;
         skid_full   <= 1'b0;
      end else begin
         if (!out_valid_q || out_ready) begin
            if (skid_full) begin
               out_q       <= skid_q;
               out_valid_q <= 1'b1;
               skid_full   <= 1'b0;
            end else if (in_xfer) begin
               out_q       <= dec_next;
               out_valid_q <= 1'b1;
            end else begin
               out_valid_q <= 1'b0;
            end
         end else if (in_xfer) begin
            skid_q    <= dec_next;
            skid_full <= 1'b1;
         end

         if (in_xfer) begin
            if (dec_count != {CNT_W{1'b1}})
               dec_count <= dec_count + CNT_W'(1);
            if (dec_next.illegal && ill_count != {CNT_W{1'b1}})
               ill_count <= ill_count + CNT_W'(1);
         end
      end
   end

   assign out_valid = out_valid_q;
   assign opcode    = out_q.opcode;
   assign rdst2     = out_q.rdst2;
   assign rdst1     = out_q.rdst1;
   assign rsrc2     = out_q.rsrc2;
   assign rsrc1     = out_q.rsrc1;
   assign rsrc_add  = out_q.rsrc_add;
   assign rdst_add  = out_q.rdst_add;
   assign immediate = out_q.immediate;
   assign we2       = out_q.we2;
   assign we1       = out_q.we1;
   assign re2       = out_q.re2;
   assign re1       = out_q.re1;
   assign mem_rd    = out_q.mem_rd;
   assign mem_wr    = out_q.mem_wr;
   assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Purpose : randomized + directed bench for decode_stage with a queue scoreboard.
// Latency : n/a (bench).
// Backpressure: bench drives out_ready randomly; monitor checks every consumed output.
module tb_decode_stage;

   typedef struct packed {
      logic [5:0]  opcode;
      logic [4:0]  rdst2;
      logic [4:0]  rdst1;
      logic [4:0]  rsrc2;
      logic [4:0]  rsrc1;
      logic [7:0]  rsrc_add;
      logic [7:0]  rdst_add;
      logic [15:0] immediate;
      logic        we2;
      logic        we1;
      logic        re2;
      logic        re1;
      logic        mem_rd;
      logic        mem_wr;
      logic        illegal;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // main instance (defaults)
   logic        rst, flush, in_valid, out_ready;
   logic [31:0] code;
   logic        in_ready, out_valid;
   logic [5:0]  opcode;
   logic [4:0]  rdst2, rdst1, rsrc2, rsrc1;
   logic [7:0]  rsrc_add, rdst_add;
   logic [15:0] immediate;
   logic        we2, we1, re2, re1, mem_rd, mem_wr, illegal;
   logic [15:0] dec_count, ill_count;
   exp_t        dut_vec;

   // saturation instance (CNT_W=2)
   logic        s_flush, s_valid, s_oready;
   logic [31:0] s_code;
   logic        s_ready, s_ovalid;
   logic [5:0]  s_opcode;
   logic [4:0]  s_rdst2, s_rdst1, s_rsrc2, s_rsrc1;
   logic [7:0]  s_rsrc_add, s_rdst_add;
   logic [15:0] s_immediate;
   logic        s_we2, s_we1, s_re2, s_re1, s_mem_rd, s_mem_wr, s_illegal;
   logic [1:0]  s_dec_count, s_ill_count;
   exp_t        s_vec;

   decode_stage #(.REG_W(5), .ADDR_W(8), .ALU_LAST(16), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .code(code),
      .out_valid(out_valid), .out_ready(out_ready),
      .opcode(opcode), .rdst2(rdst2), .rdst1(rdst1), .rsrc2(rsrc2), .rsrc1(rsrc1),
      .rsrc_add(rsrc_add), .rdst_add(rdst_add), .immediate(immediate),
      .we2(we2), .we1(we1), .re2(re2), .re1(re1),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .illegal(illegal),
      .dec_count(dec_count), .ill_count(ill_count)
   );

   decode_stage #(.REG_W(5), .ADDR_W(8), .ALU_LAST(16), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .flush(s_flush),
      .in_valid(s_valid), .in_ready(s_ready), .code(s_code),
      .out_valid(s_ovalid), .out_ready(s_oready),
      .opcode(s_opcode), .rdst2(s_rdst2), .rdst1(s_rdst1), .rsrc2(s_rsrc2), .rsrc1(s_rsrc1),
      .rsrc_add(s_rsrc_add), .rdst_add(s_rdst_add), .immediate(s_immediate),
      .we2(s_we2), .we1(s_we1), .re2(s_re2), .re1(s_re1),
      .mem_rd(s_mem_rd), .mem_wr(s_mem_wr), .illegal(s_illegal),
      .dec_count(s_dec_count), .ill_count(s_ill_count)
   );

   assign dut_vec = {opcode, rdst2, rdst1, rsrc2, rsrc1, rsrc_add, rdst_add, immediate,
                     we2, we1, re2, re1, mem_rd, mem_wr, illegal};
   assign s_vec   = {s_opcode, s_rdst2, s_rdst1, s_rsrc2, s_rsrc1, s_rsrc_add, s_rdst_add,
                     s_immediate, s_we2, s_we1, s_re2, s_re1, s_mem_rd, s_mem_wr, s_illegal};

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input exp_t act, input exp_t req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic chk_n(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Reference decode written from the format table.
   function automatic exp_t model(input logic [31:0] c);
      exp_t e;
      int   op;
      e        = '0;
      op       = int'(c[31:26]);
      e.opcode = c[31:26];
      if (op == 0) begin
         e.rdst2 = c[25:21]; e.immediate = c[15:0]; e.we2 = 1'b1;
      end else if (op == 1) begin
         e.rdst2 = c[25:21]; e.rsrc2 = c[4:0]; e.we2 = 1'b1; e.re2 = 1'b1;
      end else if (op == 2) begin
         e.rdst2 = c[25:21]; e.rsrc_add = c[7:0]; e.we2 = 1'b1; e.mem_rd = 1'b1;
      end else if (op == 3) begin
         e.rdst_add = c[25:18]; e.rsrc2 = c[4:0]; e.re2 = 1'b1; e.mem_wr = 1'b1;
      end else if (op <= 16) begin
         e.rdst2 = c[25:21]; e.rdst1 = c[20:16]; e.rsrc2 = c[9:5]; e.rsrc1 = c[4:0];
         e.we2 = 1'b1; e.we1 = 1'b1; e.re2 = 1'b1; e.re1 = 1'b1;
      end else begin
         e.illegal = 1'b1;
      end
      return e;
   endfunction

   // Scoreboard: queue holds every accepted, not-yet-delivered instruction.
   exp_t q[$];
   int   m_dec = 0;
   int   m_ill = 0;
   bit   mon_en = 1'b0;
   bit   hold_prev = 1'b0;
   exp_t prev_vec;

   always @(negedge clk) begin
      if (mon_en) begin
         exp_t e;
         bit   exp_ready;
         exp_ready = (q.size() < 2);
         if (hold_prev) chk("hold_stable", dut_vec, prev_vec);
         chk_n("out_valid", int'(out_valid), int'(q.size() > 0));
         chk_n("in_ready", int'(in_ready), int'(exp_ready));
         chk_n("dec_count", int'(dec_count), m_dec);
         chk_n("ill_count", int'(ill_count), m_ill);
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk_n("unexpected_output", 1, 0);
            end else begin
               e = q.pop_front();
               chk("payload", dut_vec, e);
            end
         end
         hold_prev = out_valid && !out_ready && !flush && !rst;
         prev_vec  = dut_vec;
         if (rst) begin
            q.delete();
            m_dec = 0;
            m_ill = 0;
         end else if (flush) begin
            q.delete();
         end else if (in_valid && exp_ready) begin
            e = model(code);
            q.push_back(e);
            if (m_dec < 65535) m_dec++;
            if (e.illegal && m_ill < 65535) m_ill++;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      exp_t        e;
      logic [31:0] ca, cb, cc, rc;
      logic [31:0] s_codes [5];

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; code = '0;
      s_flush = 1'b0; s_valid = 1'b0; s_oready = 1'b1; s_code = '0;
      step();
      mon_en = 1'b1;
      step();
      rst = 1'b0;

      // reset state
      chk("reset_fields", dut_vec, '0);
      chk_n("reset_out_valid", int'(out_valid), 0);
      chk_n("reset_in_ready", int'(in_ready), 1);
      chk_n("reset_counts", int'(dec_count) + int'(ill_count), 0);

      // LDI
      out_ready = 1'b1; in_valid = 1'b1; code = 32'h0020_1234;
      step();
      in_valid = 1'b0;
      e = '0; e.rdst2 = 5'd1; e.immediate = 16'h1234; e.we2 = 1'b1;
      chk_n("ldi_valid", int'(out_valid), 1);
      chk("ldi_fields", dut_vec, e);
      step();

      // ALU then illegal
      do_reset();
      in_valid = 1'b1; code = {6'd5, 5'd3, 5'd4, 6'd0, 5'd5, 5'd6};
      step();
      code = 32'hFFFF_FFFF;
      e = '0; e.opcode = 6'd5; e.rdst2 = 5'd3; e.rdst1 = 5'd4; e.rsrc2 = 5'd5; e.rsrc1 = 5'd6;
      e.we2 = 1'b1; e.we1 = 1'b1; e.re2 = 1'b1; e.re1 = 1'b1;
      chk("alu_fields", dut_vec, e);
      step();
      in_valid = 1'b0;
      e = '0; e.opcode = 6'd63; e.illegal = 1'b1;
      chk("illegal_fields", dut_vec, e);
      chk_n("illegal_ill_count", int'(ill_count), 1);
      chk_n("illegal_dec_count", int'(dec_count), 2);
      step();

      // backpressure: three offered, two accepted
      do_reset();
      out_ready = 1'b0; in_valid = 1'b1;
      ca = 32'h0443_0011; cb = 32'h08A0_00C7; cc = 32'h0C7C_0019;
      code = ca; step();
      code = cb; step();
      code = cc; step();
      chk_n("bp_in_ready", int'(in_ready), 0);
      chk_n("bp_accepted", int'(dec_count), 2);
      chk("bp_head", dut_vec, model(ca));
      out_ready = 1'b1; in_valid = 1'b0;
      step();
      chk("bp_second", dut_vec, model(cb));
      chk_n("bp_second_valid", int'(out_valid), 1);
      chk_n("bp_ready_back", int'(in_ready), 1);
      step();
      chk_n("bp_drained", int'(out_valid), 0);

      // flush with both registers full
      do_reset();
      out_ready = 1'b0; in_valid = 1'b1;
      code = ca; step();
      code = cb; step();
      chk_n("fl_full", int'(in_ready), 0);
      flush = 1'b1; code = cc;
      step();
      flush = 1'b0; in_valid = 1'b0;
      chk_n("fl_out_valid", int'(out_valid), 0);
      chk_n("fl_in_ready", int'(in_ready), 1);
      chk_n("fl_dec_count", int'(dec_count), 2);
      // input offered during flush while ready is dropped
      in_valid = 1'b1; flush = 1'b1; code = ca;
      step();
      in_valid = 1'b0; flush = 1'b0;
      chk_n("fl_drop_valid", int'(out_valid), 0);
      chk_n("fl_drop_count", int'(dec_count), 2);

      // reset mid-stream
      out_ready = 1'b0; in_valid = 1'b1; code = 32'h0020_1234;
      step();
      in_valid = 1'b0;
      chk_n("mid_valid", int'(out_valid), 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_fields", dut_vec, '0);
      chk_n("mid_rst_valid", int'(out_valid), 0);
      chk_n("mid_rst_counts", int'(dec_count) + int'(ill_count), 0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rc = $urandom;
         rc[31:26] = 6'($urandom_range(0, 63));
         code      = rc;
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 40) == 0);
         rst       = ($urandom_range(0, 400) == 0);
         step();
      end
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (4) step();
      chk_n("drain_empty", q.size(), 0);

      // counter saturation on the CNT_W=2 instance
      do_reset();
      s_codes[0] = 32'hFC00_0000;
      s_codes[1] = 32'hFFFF_0001;
      s_codes[2] = 32'h4400_0000;
      s_codes[3] = 32'hFC12_3456;
      s_codes[4] = 32'h0060_ABCD;
      s_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         s_code = s_codes[i];
         step();
      end
      s_valid = 1'b0;
      chk_n("sat_dec_count", int'(s_dec_count), 3);
      chk_n("sat_ill_count", int'(s_ill_count), 3);
      chk_n("sat_valid", int'(s_ovalid), 1);
      chk_n("sat_ready", int'(s_ready), 1);
      chk("sat_last", s_vec, model(s_codes[4]));
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter REG_W, default 5, register-index width (legal 1..5); each field is taken from the low REG_W bits of its 5-bit slot.
REQ-002 SHALL have parameter ADDR_W, default 8, memory-address width (legal 1..8); the field is taken from the low ADDR_W bits of its 8-bit slot.
REQ-003 SHALL have parameter ALU_LAST, default 16, highest legal ALU opcode (legal 4..63).
REQ-004 SHALL have parameter CNT_W, default 16, statistics counter width.
REQ-005 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-006 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have ports: flush  in  1  discard all held instructions.
REQ-008 SHALL have ports: in_valid  in  1; in_ready  out  1; code  in  32  instruction word.
REQ-009 SHALL have ports: out_valid  out  1; out_ready  in  1.
REQ-010 SHALL have ports: opcode  out  6; rdst2, rdst1, rsrc2, rsrc1  out  REG_W each; rsrc_add, rdst_add  out  ADDR_W each; immediate  out  16.
REQ-011 SHALL have ports: we2, we1, re2, re1, mem_rd, mem_wr, illegal  out  1 each, decoded enables.
REQ-012 SHALL have ports: dec_count, ill_count  out  CNT_W each.

Function
REQ-013 Field slots SHALL be: opcode code[31:26], rdst2 [25:21], rdst1 [20:16], rsrc2 [9:5] (ALU) or [4:0] (MOV/ST), rsrc1 [4:0], rsrc_add [7:0], rdst_add [25:18], immediate [15:0].
REQ-014 Opcode 0 (LDI) SHALL drive rdst2 and immediate, and assert we2.
REQ-015 Opcode 1 (MOV) SHALL drive rdst2 and rsrc2 from [4:0], and assert we2 and re2.
REQ-016 Opcode 2 (LD) SHALL drive rdst2 and rsrc_add, and assert we2 and mem_rd.
REQ-017 Opcode 3 (ST) SHALL drive rdst_add and rsrc2 from [4:0], and assert re2 and mem_wr.
REQ-018 Opcodes 4..ALU_LAST SHALL drive rdst2, rdst1, rsrc2 and rsrc1, and assert we2, we1, re2 and re1.
REQ-019 Opcodes above ALU_LAST SHALL assert illegal with all enables and fields 0.
REQ-020 Every field and enable not used by the current format SHALL be 0; no value SHALL be held over from a previous instruction.
REQ-021 opcode output SHALL always equal code[31:26] of the presented instruction.
REQ-022 All outputs SHALL be registered; latency SHALL be 1 cycle from input transfer to out_valid when the output stage is empty.
REQ-023 A transfer SHALL occur on a rising edge where valid and ready are both 1; out_valid and the payload SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 Storage SHALL be an output register plus a one-entry skid register.
REQ-025 in_ready SHALL be the registered negation of skid-full, so it has no combinational path from out_ready.
REQ-026 An input transfer while the output is empty or being consumed SHALL load the output register.
REQ-027 An input transfer while the output is held SHALL load the skid register.
REQ-028 When the output is consumed and the skid register is full, the skid contents SHALL move to the output register in that same cycle, and in_ready SHALL rise on the next cycle.
REQ-029 Sustained in_valid=out_ready=1 SHALL give one instruction per cycle throughput.
REQ-030 flush=1 SHALL clear out_valid and skid-full on the next edge, with in_ready=1 afterwards; an input offered in the flush cycle SHALL be dropped and not counted.
REQ-031 dec_count SHALL increment on each non-flushed input transfer; ill_count SHALL increment on each such transfer with an illegal opcode.
REQ-032 Both counters SHALL saturate at 2^CNT_W-1, and flush SHALL NOT alter them.

Reset
REQ-033 On rst=1 at a clock edge: out_valid=0, skid empty, in_ready=1, all fields, enables, illegal and opcode 0, and both counters 0.
REQ-034 rst SHALL take priority over flush and over any transfer, and any instruction in flight SHALL be discarded.

Verification
REQ-035 Send code=0x0020_1234 (LDI) with out_ready=1 -> next cycle out_valid=1, rdst2=1, immediate=0x1234, we2=1, all other fields and enables 0.
REQ-036 Send ALU opcode 5 with rdst2=3, rdst1=4, rsrc2=5, rsrc1=6, then opcode 63 -> first output has we2=we1=re2=re1=1 with the register fields above; second output has illegal=1, every field 0, ill_count=1, dec_count=2.
REQ-037 Hold out_ready=0 and offer three instructions -> exactly two are accepted and in_ready=0; raise out_ready -> both are delivered in order on consecutive cycles, with no loss or duplication.
REQ-038 Assert flush while both the output and skid registers are full -> next cycle out_valid=0 and in_ready=1, with counters unchanged.
REQ-039 Assert rst mid-stream with out_valid=1 -> next cycle all outputs and counters are 0.
REQ-040 Use CNT_W=2 and send five instructions -> dec_count=3, saturated.
